// File: rtl/zx_cart_pkg.sv
// zx_cart_pkg: shared types and constants for the ZX cartridge bus controller.
// FSM state enum, I/O port decode keys, ctl bit indices and the debug view.
package zx_cart_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IO_WR    = 2'd1,
      IO_RD    = 2'd2,
      WAIT_END = 2'd3
   } state_t;

   // Port decode keys, compared against {a15, a14, a13, a7}
   localparam logic [3:0] BANK_PORT = 4'b1100;
   localparam logic [3:0] CTL_PORT  = 4'b1010;

   // ctl register bit indices
   localparam int CTL_DISABLE = 7;
   localparam int CTL_LOCK    = 6;

   // Internal view exposed for observation of the FSM and registers
   typedef struct packed {
      state_t     state;
      logic [7:0] bank;
      logic [7:0] ctl;
      logic       locked;
   } dbg_t;

   // One-hot-low chip select for a 2-bit chip number (bit 0 is CS0)
   function automatic logic [3:0] cs_decode(input logic [1:0] sel);
      return ~(4'b0001 << sel);
   endfunction

endpackage

// File: rtl/zx_cart_bus_ctrl_if.sv
// zx_cart_bus_ctrl_if: Z80 side strobes/address/data plus cartridge ROM outputs.
// master = Z80 / bus driver side, slave = the controller.
interface zx_cart_bus_ctrl_if;

   logic       iorq_n;
   logic       mreq_n;
   logic       rd_n;
   logic       wr_n;
   logic       a7;
   logic       a13;
   logic       a14;
   logic       a15;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_oe;
   logic [5:0] cr_rom_a;
   logic [3:0] cr_rom_cs;
   logic       cr_rom_oe_n;
   logic       zx_rom_blk;

   modport master (
      output iorq_n, mreq_n, rd_n, wr_n, a7, a13, a14, a15, d_in,
      input  d_out, d_oe, cr_rom_a, cr_rom_cs, cr_rom_oe_n, zx_rom_blk
   );

   modport slave (
      input  iorq_n, mreq_n, rd_n, wr_n, a7, a13, a14, a15, d_in,
      output d_out, d_oe, cr_rom_a, cr_rom_cs, cr_rom_oe_n, zx_rom_blk
   );

endinterface

// File: rtl/zx_cart_sync.sv
// zx_cart_sync: STAGES-deep flop chain bringing one asynchronous strobe into
// the clk domain. Reset loads the inactive level RESET_VAL (strobes are active
// low, so the default is 1). STAGES must be 2 or 3.
module zx_cart_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw strobe through the synchroniser chain
   always_ff @(posedge clk) begin
      if (reset) sync_q <= {STAGES{RESET_VAL}};
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zx_cart_bus_ctrl.sv
// zx_cart_bus_ctrl: Z80 cartridge bank/control port controller.
// I/O writes to the bank or ctl port are captured while the cycle is open and
// committed once IORQ is released and no memory cycle is in flight, so a bank
// switch can never land in the middle of an opcode fetch. Cycles that stay
// open for ABORT_CYCLES clocks are abandoned without a commit.
// Optional build macro ZX_CART_LOCK_EN: a committed ctl write with the LOCK bit
// set freezes bank and ctl until reset.
module zx_cart_bus_ctrl
   import zx_cart_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int ABORT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   zx_cart_bus_ctrl_if.slave bus,
   output dbg_t              dbg_o
);

   localparam int               CNT_W      = (ABORT_CYCLES < 2) ? 1 : $clog2(ABORT_CYCLES);
   localparam logic [CNT_W-1:0] ABORT_LAST = CNT_W'(ABORT_CYCLES - 1);

   state_t           state_q;
   logic [7:0]       bank_q;
   logic [7:0]       ctl_q;
   logic [7:0]       pend_q;
   logic             port_ctl_q;   // 1: last hit was ctl port, 0: bank port
   logic [CNT_W-1:0] abort_cnt_q;
   logic [CNT_W-1:0] abort_cnt_d;

   logic iorq_s, mreq_s, rd_s, wr_s;
   logic [3:0] addr_key;
   logic bank_hit, ctl_hit, port_hit;
   logic abort_hit;
   logic commit_ev, commit_en;
   logic lock_q;
   logic rom_access;

   zx_cart_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (.clk(clk), .reset(reset), .d_i(bus.iorq_n), .q_o(iorq_s));
   zx_cart_sync #(.STAGES(SYNC_STAGES)) u_sync_mreq (.clk(clk), .reset(reset), .d_i(bus.mreq_n), .q_o(mreq_s));
   zx_cart_sync #(.STAGES(SYNC_STAGES)) u_sync_rd   (.clk(clk), .reset(reset), .d_i(bus.rd_n),   .q_o(rd_s));
   zx_cart_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk), .reset(reset), .d_i(bus.wr_n),   .q_o(wr_s));

   // Address is only looked at in IDLE while synchronised IORQ is low
   assign addr_key = {bus.a15, bus.a14, bus.a13, bus.a7};
   assign bank_hit = (addr_key == BANK_PORT);
   assign ctl_hit  = (addr_key == CTL_PORT);
   assign port_hit = bank_hit | ctl_hit;

   assign abort_cnt_d = abort_cnt_q + CNT_W'(1);
   assign abort_hit   = (abort_cnt_q == ABORT_LAST);

   // Commit point: IORQ released and no memory cycle in progress
   assign commit_ev = (state_q == IO_WR) && iorq_s && mreq_s;

`ifdef ZX_CART_LOCK_EN
   // Lock latches on the first committed ctl write carrying the LOCK bit
   always_ff @(posedge clk) begin
      if (reset)                                         lock_q <= 1'b0;
      else if (commit_en && port_ctl_q && pend_q[CTL_LOCK]) lock_q <= 1'b1;
   end
   assign commit_en = commit_ev && !lock_q;
`else
   assign lock_q    = 1'b0;
   assign commit_en = commit_ev;
`endif

   // Bus-cycle FSM: port decode, write capture, deferred commit and abort
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bank_q      <= '0;
         ctl_q       <= '0;
         pend_q      <= '0;
         port_ctl_q  <= 1'b0;
         abort_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               abort_cnt_q <= '0;
               if (!iorq_s) begin
                  if (!rd_s && !wr_s) begin
                     state_q <= WAIT_END;
                  end else if (!rd_s || !wr_s) begin
                     if (port_hit) begin
                        // exactly one of rd/wr is low here
                        state_q    <= wr_s ? IO_RD : IO_WR;
                        port_ctl_q <= ctl_hit;
                     end else begin
                        state_q <= WAIT_END;
                     end
                  end
               end
            end
            IO_WR: begin
               if (iorq_s && mreq_s) begin
                  if (commit_en) begin
                     if (port_ctl_q) ctl_q  <= pend_q;
                     else            bank_q <= pend_q;
                  end
                  state_q <= IDLE;
               end else if (abort_hit) begin
                  state_q <= WAIT_END;
               end else begin
                  abort_cnt_q <= abort_cnt_d;
                  if (!iorq_s) pend_q <= bus.d_in;
               end
            end
            IO_RD: begin
               if (iorq_s) begin
                  state_q <= IDLE;
               end else if (abort_hit) begin
                  state_q <= WAIT_END;
               end else begin
                  abort_cnt_q <= abort_cnt_d;
               end
            end
            WAIT_END: begin
               if (iorq_s) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read-back path; the drive enable uses raw strobes so the bus is released
   // the moment the Z80 ends the cycle
   assign bus.d_out = port_ctl_q ? ctl_q : bank_q;
   assign bus.d_oe  = (state_q == IO_RD) && !bus.iorq_n && !bus.rd_n;

   // Cartridge page/chip select: bank[7:6] selects the chip, bank[5:0] the page
   assign bus.cr_rom_a  = bus.a13 ? bank_q[5:0] : 6'd0;
   assign bus.cr_rom_cs = bus.a13 ? cs_decode(bank_q[7:6]) : 4'b1110;

   // Internal ROM is blocked whenever the cartridge answers a low-16K read
   assign rom_access      = !bus.mreq_n && !bus.rd_n && !bus.a15 && !bus.a14 && !ctl_q[CTL_DISABLE];
   assign bus.cr_rom_oe_n = !rom_access;
   assign bus.zx_rom_blk  = rom_access;

   assign dbg_o.state  = state_q;
   assign dbg_o.bank   = bank_q;
   assign dbg_o.ctl    = ctl_q;
   assign dbg_o.locked = lock_q;

endmodule

// File: tb/tb_zx_cart_bus_ctrl.sv
// tb_zx_cart_bus_ctrl: directed bench for zx_cart_bus_ctrl with a queue-based
// scoreboard. Drivers push expected values; a negedge monitor pops them when
// the DUT presents a read (d_oe rise), a memory read starts, or a probe fires.
module tb_zx_cart_bus_ctrl;
   import zx_cart_pkg::*;

   typedef struct packed {
      logic [1:0] state;
      logic [7:0] bank;
      logic [5:0] rom_a;
      logic [3:0] cs;
      logic       oe_n;
      logic       blk;
      logic       d_oe;
      logic [7:0] d_out;
   } snap_t;

   logic clk = 1'b0;
   logic reset;
   dbg_t dbg;

   always #5 clk = ~clk;

   zx_cart_bus_ctrl_if bus ();

   zx_cart_bus_ctrl #(.SYNC_STAGES(2), .ABORT_CYCLES(255)) dut (
      .clk(clk), .reset(reset), .bus(bus), .dbg_o(dbg)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_rd_q[$];
   string       rd_name_q[$];
   logic [11:0] exp_mem_q[$];
   string       mem_name_q[$];
   snap_t       exp_snap_q[$];
   string       snap_name_q[$];

   logic        probe_req = 1'b0;
   logic        d_oe_prev = 1'b0;
   logic        mem_prev  = 1'b0;
   logic        mem_now;
   logic [7:0]  e_rd;
   logic [11:0] e_mem, a_mem;
   snap_t       e_snap, a_snap;
   string       nm;

   function automatic snap_t mk(input logic [1:0] st, input logic [7:0] bank, input logic [5:0] rom_a,
                                input logic [3:0] cs, input logic oe_n, input logic blk,
                                input logic d_oe, input logic [7:0] d_out);
      snap_t s;
      s = '{state: st, bank: bank, rom_a: rom_a, cs: cs, oe_n: oe_n, blk: blk, d_oe: d_oe, d_out: d_out};
      return s;
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("state=%0d bank=%02h rom_a=%0d cs=%b oe_n=%b blk=%b d_oe=%b d_out=%02h",
                       s.state, s.bank, s.rom_a, s.cs, s.oe_n, s.blk, s.d_oe, s.d_out);
   endfunction

   // Monitor: compare whatever the DUT presents against the scoreboard
   always @(negedge clk) begin
      if (bus.d_oe && !d_oe_prev) begin
         checks++;
         if (exp_rd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read d_out=%02h with no read expected", bus.d_out);
         end else begin
            e_rd = exp_rd_q.pop_front();
            nm   = rd_name_q.pop_front();
            if (bus.d_out !== e_rd) begin
               errors++;
               $display("FAIL %s d_out got %02h expected %02h", nm, bus.d_out, e_rd);
            end
         end
      end
      d_oe_prev = bus.d_oe;

      mem_now = !bus.mreq_n && !bus.rd_n;
      if (mem_now && !mem_prev) begin
         checks++;
         a_mem = {bus.cr_rom_a, bus.cr_rom_cs, bus.cr_rom_oe_n, bus.zx_rom_blk};
         if (exp_mem_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_mem_read outputs %03h with nothing expected", a_mem);
         end else begin
            e_mem = exp_mem_q.pop_front();
            nm    = mem_name_q.pop_front();
            if (a_mem !== e_mem) begin
               errors++;
               $display("FAIL %s rom_a=%0d cs=%b oe_n=%b blk=%b expected rom_a=%0d cs=%b oe_n=%b blk=%b",
                        nm, a_mem[11:6], a_mem[5:2], a_mem[1], a_mem[0],
                        e_mem[11:6], e_mem[5:2], e_mem[1], e_mem[0]);
            end
         end
      end
      mem_prev = mem_now;

      if (probe_req) begin
         checks++;
         a_snap = mk(dbg.state, dbg.bank, bus.cr_rom_a, bus.cr_rom_cs, bus.cr_rom_oe_n,
                     bus.zx_rom_blk, bus.d_oe, bus.d_out);
         if (exp_snap_q.size() == 0) begin
            errors++;
            $display("FAIL probe_without_expectation got %s", fmt(a_snap));
         end else begin
            e_snap = exp_snap_q.pop_front();
            nm     = snap_name_q.pop_front();
            if (a_snap !== e_snap) begin
               errors++;
               $display("FAIL %s got %s expected %s", nm, fmt(a_snap), fmt(e_snap));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_addr(input logic [15:0] a);
      bus.a15 = a[15]; bus.a14 = a[14]; bus.a13 = a[13]; bus.a7 = a[7];
   endtask

   task automatic bus_idle();
      bus.iorq_n = 1'b1; bus.mreq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus_idle();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic probe(input string name, input snap_t exp);
      @(posedge clk); #1;
      exp_snap_q.push_back(exp);
      snap_name_q.push_back(name);
      probe_req = 1'b1;
      @(negedge clk); #1;
      probe_req = 1'b0;
   endtask

   task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
      @(posedge clk); #1;
      set_addr(addr);
      bus.d_in = data; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
      repeat (6) @(posedge clk);
      #1 bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
      repeat (6) @(posedge clk);
   endtask

   task automatic io_read(input string name, input logic [15:0] addr, input logic [7:0] exp);
      @(posedge clk); #1;
      exp_rd_q.push_back(exp);
      rd_name_q.push_back(name);
      set_addr(addr);
      bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
      repeat (8) @(posedge clk);
      #1 bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic io_read_miss(input logic [15:0] addr);
      @(posedge clk); #1;
      set_addr(addr);
      bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
      repeat (8) @(posedge clk);
      #1 bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic mem_read(input string name, input logic [15:0] addr, input logic [5:0] rom_a,
                           input logic [3:0] cs, input logic oe_n, input logic blk);
      @(posedge clk); #1;
      exp_mem_q.push_back({rom_a, cs, oe_n, blk});
      mem_name_q.push_back(name);
      set_addr(addr);
      bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.mreq_n = 1'b1; bus.rd_n = 1'b1;
      @(posedge clk);
   endtask

   // Watchdog so a stuck run still ends
   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1;
      bus_idle();
      set_addr(16'h0000);
      bus.d_in = 8'h00;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values with a13 low and high
      probe("reset_a13_0", mk(IDLE, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      set_addr(16'h2000);
      probe("reset_a13_1", mk(IDLE, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));

      // Bank write, read-back and page decode
      io_write(16'hC000, 8'hA5);
      io_read("rd_bank_a5", 16'hC000, 8'hA5);
      mem_read("mem_a5_a13_1", 16'h2000, 6'd37, 4'b1011, 1'b0, 1'b1);
      mem_read("mem_a5_a13_0", 16'h0000, 6'd0, 4'b1110, 1'b0, 1'b1);
      io_write(16'hC000, 8'h3F);
      mem_read("mem_3f_a13_1", 16'h2000, 6'd63, 4'b1110, 1'b0, 1'b1);
      io_write(16'hC000, 8'hC1);
      mem_read("mem_c1_a13_1", 16'h3000, 6'd1, 4'b0111, 1'b0, 1'b1);
      io_read("rd_ctl_zero", 16'hA000, 8'h00);

      // ctl DISABLE bit gates the internal-ROM block
      io_write(16'hA000, 8'h80);
      io_read("rd_ctl_80", 16'hA000, 8'h80);
      mem_read("mem_disabled_1000", 16'h1000, 6'd0, 4'b1110, 1'b1, 1'b0);
      mem_read("mem_disabled_2000", 16'h2000, 6'd1, 4'b0111, 1'b1, 1'b0);
      io_write(16'hA000, 8'h00);
      mem_read("mem_enabled_1000", 16'h1000, 6'd0, 4'b1110, 1'b0, 1'b1);
      mem_read("mem_high_8000", 16'h8000, 6'd0, 4'b1110, 1'b1, 1'b0);

      // Port misses leave registers alone and never drive the bus
      io_write(16'hC080, 8'h55);
      io_write(16'hE000, 8'h66);
      io_write(16'h4000, 8'h77);
      io_read_miss(16'hC080);
      io_read("rd_ctl_after_miss", 16'hA000, 8'h00);
      io_read("rd_bank_after_miss", 16'hC000, 8'hC1);

      // rd and wr both low on a port hit goes to WAIT_END
      @(posedge clk); #1;
      set_addr(16'hC000);
      bus.iorq_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0;
      repeat (4) @(posedge clk);
      probe("rdwr_both_low", mk(WAIT_END, 8'hC1, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'hC1));
      @(posedge clk); #1;
      bus_idle();
      repeat (5) @(posedge clk);

      // Commit deferred while MREQ is held low past the IORQ release
      do_reset();
      @(posedge clk); #1;
      set_addr(16'hC000);
      bus.d_in = 8'h40; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
      repeat (6) @(posedge clk);
      #1 bus.mreq_n = 1'b0;
      @(posedge clk);
      #1 bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
      repeat (4) @(posedge clk);
      probe("defer_hold", mk(IO_WR, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      @(posedge clk); #1;
      bus.mreq_n = 1'b1;
      probe("defer_raw_release", mk(IO_WR, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      probe("defer_sync_high", mk(IO_WR, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      probe("defer_committed", mk(IDLE, 8'h40, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h40));
      repeat (3) @(posedge clk);
      io_read("rd_bank_40", 16'hC000, 8'h40);

      // Write held open for 300 clocks is aborted with no commit
      do_reset();
      @(posedge clk); #1;
      set_addr(16'hC000);
      bus.d_in = 8'h11; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
      repeat (290) @(posedge clk);
      probe("abort_wait_end", mk(WAIT_END, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      repeat (9) @(posedge clk);
      #1 bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
      repeat (5) @(posedge clk);
      probe("abort_idle", mk(IDLE, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      io_read("rd_bank_after_abort", 16'hC000, 8'h00);

      // Reset in the middle of IO_WR discards the pending write
      io_write(16'hC000, 8'h5A);
      @(posedge clk); #1;
      set_addr(16'hC000);
      bus.d_in = 8'h77; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
      repeat (5) @(posedge clk);
      probe("mid_wr_before_reset", mk(IO_WR, 8'h5A, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h5A));
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      probe("mid_wr_reset_a13_0", mk(IDLE, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      set_addr(16'h2000);
      probe("mid_wr_reset_a13_1", mk(IDLE, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));
      repeat (6) @(posedge clk);
      probe("mid_wr_no_late_commit", mk(IDLE, 8'h00, 6'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 8'h00));

`ifdef ZX_CART_LOCK_EN
      // Lock freezes bank/ctl until reset; read-back keeps working
      do_reset();
      io_write(16'hA000, 8'h40);
      io_write(16'hC000, 8'hC0);
      io_read("lock_bank_dropped", 16'hC000, 8'h00);
      io_read("lock_ctl_readback", 16'hA000, 8'h40);
      do_reset();
      io_write(16'hC000, 8'hC0);
      io_read("unlock_bank_write", 16'hC000, 8'hC0);
`else
      // ctl bit 6 is ordinary storage
      do_reset();
      io_write(16'hA000, 8'h40);
      io_write(16'hC000, 8'hC0);
      io_read("nolock_bank_write", 16'hC000, 8'hC0);
      io_read("nolock_ctl_readback", 16'hA000, 8'h40);
`endif

      repeat (10) @(posedge clk);

      // Every expectation must have been consumed by the monitor
      checks++;
      if (exp_rd_q.size() != 0) begin
         errors++;
         $display("FAIL rd_queue_drain got %0d pending expected 0", exp_rd_q.size());
      end
      checks++;
      if (exp_mem_q.size() != 0) begin
         errors++;
         $display("FAIL mem_queue_drain got %0d pending expected 0", exp_mem_q.size());
      end
      checks++;
      if (exp_snap_q.size() != 0) begin
         errors++;
         $display("FAIL probe_queue_drain got %0d pending expected 0", exp_snap_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/zx_cart_bus_ctrl.md
ZX_CART_BUS_CTRL -- requirements
Module: zx_cart_bus_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the Z80 strobe synchronisers, legal range 2..3.
REQ-002 SHALL have parameter ABORT_CYCLES, default 255: clocks an I/O cycle may stay open before it is aborted.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iorq_n, mreq_n, rd_n, wr_n  input  1 each  raw asynchronous Z80 strobes, active low.
REQ-006 a7, a13, a14, a15  input  1 each  Z80 address bits.
REQ-007 d_in  input  8  Z80 data bus, input side.
REQ-008 d_out  output  8  read-back data.
REQ-009 d_oe  output  1  data bus drive enable, active high.
REQ-010 cr_rom_a  output  6  cartridge page address.
REQ-011 cr_rom_cs  output  4  one-hot-low chip selects; bit 0 is CS0.
REQ-012 cr_rom_oe_n, zx_rom_blk  output  1 each  cartridge ROM read enable (active low) and internal ROM block (active high).

Function
REQ-013 Strobes SHALL be synchronised through SYNC_STAGES flops; address and data SHALL be sampled only while the synchronised strobe is low.
REQ-014 Port decode SHALL be: bank = a15 & a14 & !a13 & !a7; ctl = a15 & !a14 & a13 & !a7.
REQ-015 The FSM SHALL have states IDLE, IO_WR, IO_RD and WAIT_END.
REQ-016 From IDLE, the first clock with sync iorq_n=0, sync wr_n=0 and a port hit SHALL enter IO_WR; with sync rd_n=0 and a port hit it SHALL enter IO_RD; a miss, or rd_n and wr_n both low, SHALL enter WAIT_END.
REQ-017 While in IO_WR, d_in SHALL be captured into a pending register every clock.
REQ-018 The pending value SHALL commit to bank or ctl on the clock on which sync iorq_n is seen high, so the register changes exactly one clock after the cycle end is detected; the FSM then returns to IDLE.
REQ-019 A commit SHALL never occur while sync mreq_n=0; it SHALL be deferred until mreq_n is released, so no bank switch happens mid-fetch.
REQ-020 IO_RD SHALL return to IDLE on sync iorq_n high, and WAIT_END SHALL return to IDLE on sync iorq_n high.
REQ-021 An abort counter SHALL count clocks in IO_WR/IO_RD; reaching ABORT_CYCLES SHALL enter WAIT_END with no commit.
REQ-022 d_oe SHALL be (state==IO_RD) & !iorq_n & !rd_n (raw strobes), so the bus is released combinationally at cycle end.
REQ-023 d_out SHALL equal bank or ctl according to the latched port.
REQ-024 chip_sel SHALL be bank[7:6] and page SHALL be bank[5:0].
REQ-025 When a13=1: cr_rom_a = page and cr_rom_cs is low on bit chip_sel only. When a13=0: cr_rom_a = 0 and cr_rom_cs = 4'b1110.
REQ-026 rom_access SHALL be !mreq_n & !rd_n & !a15 & !a14 & !ctl[7] (raw, combinational); cr_rom_oe_n = !rom_access and zx_rom_blk = rom_access.

Reset
REQ-027 reset SHALL clear bank, ctl, the pending register, the abort counter and the synchronisers (to the inactive level), and SHALL force the FSM to IDLE.
REQ-028 Reset values SHALL be: d_oe=0, d_out=0, cr_rom_a=0, cr_rom_cs=4'b1110, cr_rom_oe_n and zx_rom_blk per REQ-026 with ctl=0.
REQ-029 A reset asserted mid-cycle SHALL discard the pending write.

Configuration
REQ-030 With ZX_CART_LOCK_EN defined, a committed ctl write with bit 6=1 SHALL set a lock, and later commits to bank or ctl SHALL be dropped until reset; read-back SHALL still work.
REQ-031 Without ZX_CART_LOCK_EN, ctl bit 6 SHALL be plain storage.

Structure
REQ-032 A package zx_cart_pkg SHALL hold the FSM state enum, the port decode constants and the ctl bit indices (DISABLE=7, LOCK=6).
REQ-033 Sub-module zx_cart_sync SHALL be a parameterised synchroniser, instantiated once per strobe.

Verification
REQ-034 Write 0xA5 to 0xC000, then read 0xC000 -> d_out=0xA5 while d_oe=1; then a13=1 memory read -> cr_rom_a=37, cr_rom_cs=4'b1011.
REQ-035 Write 0x80 to 0xA000, then memory read at 0x1000 -> cr_rom_oe_n=1, zx_rom_blk=0; write 0x00 -> cr_rom_oe_n=0, zx_rom_blk=1.
REQ-036 Write 0x40 to 0xC000 while mreq_n is held low past the iorq_n release -> bank still 0x00 until mreq_n rises, 0x40 one clock after sync mreq_n is high.
REQ-037 Hold iorq_n and wr_n low for 300 clocks at 0xC000 with data 0x11 -> abort, bank unchanged at 0x00.
REQ-038 Pulse reset mid IO_WR -> FSM in IDLE, bank=0x00, cr_rom_cs=4'b1110 for a13=0 and a13=1.
REQ-039 With ZX_CART_LOCK_EN: write 0x40 to 0xA000, then 0xC0 to 0xC000 -> bank reads 0x00; after reset the write succeeds.
